// File: rtl/fsic_phase_ctrl_pkg.sv
// Shared constants for the io_serdes phase-lock controller: FSM encoding and
// error-counter sizing, plus the saturating increment used on err_cnt.
package fsic_phase_ctrl_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t IDLE    = 2'd0;
    localparam fsm_state_t ACQUIRE = 2'd1;
    localparam fsm_state_t LOCKED  = 2'd2;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/fsic_phase_lock_ctrl_if.sv
// Signal bundle between the phase-lock controller and its environment
// (phase counter, config and serializer/deserializer strobes).
interface fsic_phase_lock_ctrl_if #(
    parameter int pCLK_RATIO = 4
);
    import fsic_phase_ctrl_pkg::*;

    localparam int CW = $clog2(pCLK_RATIO);

    // No valid/ready pairs here: phase_cnt_in is sampled every ioclk cycle,
    // tx_load/rx_capture/lost_lock are single-cycle strobes with no backpressure.
    logic                 enable;
    logic [CW-1:0]        phase_cnt_in;
    logic [CW-1:0]        load_phase;
    logic                 clear_err;
    logic                 tx_load;
    logic                 rx_capture;
    logic                 locked;
    logic                 lost_lock;
    fsm_state_t           state;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output enable, phase_cnt_in, load_phase, clear_err,
        input  tx_load, rx_capture, locked, lost_lock, state, err_cnt
    );

    modport slave (
        input  enable, phase_cnt_in, load_phase, clear_err,
        output tx_load, rx_capture, locked, lost_lock, state, err_cnt
    );

endinterface

// File: rtl/fsic_phase_seq_checker.sv
// Holds the previous phase sample and classifies the current sample as a
// clean modulo-pCLK_RATIO advance (good) or not (bad).
module fsic_phase_seq_checker #(
    parameter int pCLK_RATIO = 4,
    parameter int CW         = $clog2(pCLK_RATIO)
) (
    input  logic          ioclk,
    input  logic          axis_rst,
    input  logic          clr,
    input  logic [CW-1:0] phase_cnt_in,
    output logic          good,
    output logic          bad
);

    logic [CW-1:0] prev;
    logic          prev_valid;
    logic [CW:0]   expected;
    logic          in_range;

    always_ff @(posedge ioclk) begin
        if (axis_rst || clr) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= phase_cnt_in;
            prev_valid <= 1'b1;
        end
    end

    // One extra bit so an out-of-range prev never wraps onto a legal value.
    assign expected = (prev == CW'(pCLK_RATIO - 1)) ? '0 : ({1'b0, prev} + 1'b1);
    assign in_range = ({1'b0, phase_cnt_in} < (CW+1)'(pCLK_RATIO));

    assign good = prev_valid && ({1'b0, phase_cnt_in} == expected) && in_range;
    assign bad  = prev_valid && !good;

endmodule

// File: rtl/fsic_phase_lock_ctrl.sv
// Phase-lock sequencer: acquires lock on the ioclk phase count, issues the
// per-coreclk TX load / RX capture strobes while locked, drops lock on errors.
module fsic_phase_lock_ctrl
    import fsic_phase_ctrl_pkg::*;
#(
    parameter int pCLK_RATIO   = 4,
    parameter int pLOCK_CYCLES = 8,
    parameter int pERR_LIMIT   = 2
) (
    input  logic                   ioclk,
    input  logic                   axis_rst,
    fsic_phase_lock_ctrl_if.slave  bus
);

    localparam int CW   = $clog2(pCLK_RATIO);
    localparam int GR_W = $clog2(pLOCK_CYCLES + 1);
    localparam int BR_W = $clog2(pERR_LIMIT + 1);

    localparam logic [CW-1:0]   PH_LAST = CW'(pCLK_RATIO - 1);
    localparam logic [GR_W-1:0] GR_LAST = GR_W'(pLOCK_CYCLES - 1);
    localparam logic [BR_W-1:0] BR_LAST = BR_W'(pERR_LIMIT - 1);

    fsm_state_t           state_q, state_d;
    logic [GR_W-1:0]      good_run_q, good_run_d;
    logic [BR_W-1:0]      bad_run_q, bad_run_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 lost_lock_q, lost_lock_d;
    logic                 locked_q;
    logic                 tx_load_q, tx_load_d;
    logic                 rx_capture_q, rx_capture_d;

    logic good, bad, chk_clr, sample_ok, count_bad;

    // The reference sample is re-taken whenever the controller is not running.
    assign chk_clr = !bus.enable || ((state_q != ACQUIRE) && (state_q != LOCKED));

    fsic_phase_seq_checker #(
        .pCLK_RATIO (pCLK_RATIO)
    ) u_seq_checker (
        .ioclk        (ioclk),
        .axis_rst     (axis_rst),
        .clr          (chk_clr),
        .phase_cnt_in (bus.phase_cnt_in),
        .good         (good),
        .bad          (bad)
    );

    always_comb begin
        state_d     = state_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        lost_lock_d = 1'b0;
        if (!bus.enable) begin
            state_d    = IDLE;
            good_run_d = '0;
            bad_run_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ACQUIRE;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end
                ACQUIRE: begin
                    if (good) begin
                        if (good_run_q == GR_LAST) begin
                            state_d    = LOCKED;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_run_q + 1'b1;
                        end
                    end else if (bad) begin
                        good_run_d = '0;
                    end
                end
                LOCKED: begin
                    if (bad) begin
                        if (bad_run_q == BR_LAST) begin
                            state_d     = ACQUIRE;
                            lost_lock_d = 1'b1;
                            bad_run_d   = '0;
                        end else begin
                            bad_run_d = bad_run_q + 1'b1;
                        end
                    end else if (good) begin
                        bad_run_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end
            endcase
        end
    end

    // Strobes only trust a sample that is both in LOCKED and a clean advance.
    assign sample_ok = bus.enable && (state_q == LOCKED) && good;
    assign count_bad = bus.enable && (state_q == LOCKED) && bad;

    always_comb begin
        tx_load_d    = sample_ok && (bus.phase_cnt_in == bus.load_phase);
        rx_capture_d = sample_ok && (bus.phase_cnt_in == PH_LAST);
        err_cnt_d    = err_cnt_q;
        if (bus.clear_err) begin
            err_cnt_d = '0;
        end else if (count_bad) begin
            err_cnt_d = err_cnt_inc(err_cnt_q);
        end
    end

    always_ff @(posedge ioclk) begin
        if (axis_rst) begin
            state_q      <= IDLE;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            err_cnt_q    <= '0;
            lost_lock_q  <= 1'b0;
            locked_q     <= 1'b0;
            tx_load_q    <= 1'b0;
            rx_capture_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            err_cnt_q    <= err_cnt_d;
            lost_lock_q  <= lost_lock_d;
            locked_q     <= (state_d == LOCKED);
            tx_load_q    <= tx_load_d;
            rx_capture_q <= rx_capture_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.lost_lock  = lost_lock_q;
    assign bus.tx_load    = tx_load_q;
    assign bus.rx_capture = rx_capture_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fsic_phase_lock_ctrl.sv
// Bench for fsic_phase_lock_ctrl: directed phase sequences on two instances
// (R=4/ERR=2 and R=3/ERR=400) with an expected-output queue per instance.
module tb_fsic_phase_lock_ctrl;

    localparam int W = 14;

    logic ioclk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 ioclk = ~ioclk;

    fsic_phase_lock_ctrl_if #(.pCLK_RATIO(4)) bus_a ();
    fsic_phase_lock_ctrl_if #(.pCLK_RATIO(3)) bus_b ();

    fsic_phase_lock_ctrl #(
        .pCLK_RATIO   (4),
        .pLOCK_CYCLES (8),
        .pERR_LIMIT   (2)
    ) dut_a (
        .ioclk    (ioclk),
        .axis_rst (rst_a),
        .bus      (bus_a)
    );

    fsic_phase_lock_ctrl #(
        .pCLK_RATIO   (3),
        .pLOCK_CYCLES (8),
        .pERR_LIMIT   (400)
    ) dut_b (
        .ioclk    (ioclk),
        .axis_rst (rst_b),
        .bus      (bus_b)
    );

    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];
    string        tag_qa[$];
    string        tag_qb[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // expected output vector: {state, locked, lost_lock, tx_load, rx_capture, err_cnt}
    function automatic logic [W-1:0] pk(input logic [1:0] st, input logic lk, input logic ll,
                                         input logic tx, input logic rx, input logic [7:0] ec);
        return {st, lk, ll, tx, rx, ec};
    endfunction

    task automatic check_one(input logic [W-1:0] act, input logic [W-1:0] exp, input string tag);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d lk=%b ll=%b tx=%b rx=%b err=%0d, want st=%0d lk=%b ll=%b tx=%b rx=%b err=%0d",
                     tag, act[13:12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // monitor: one queued expectation per clock, compared away from the active edge
    always @(negedge ioclk) begin
        if (exp_qa.size() != 0) begin
            check_one(pk(bus_a.state, bus_a.locked, bus_a.lost_lock, bus_a.tx_load,
                         bus_a.rx_capture, bus_a.err_cnt),
                      exp_qa.pop_front(), tag_qa.pop_front());
        end
        if (exp_qb.size() != 0) begin
            check_one(pk(bus_b.state, bus_b.locked, bus_b.lost_lock, bus_b.tx_load,
                         bus_b.rx_capture, bus_b.err_cnt),
                      exp_qb.pop_front(), tag_qb.pop_front());
        end
    end

    task automatic step_a(input logic rst, input logic en, input logic [1:0] ph,
                          input logic clr, input logic [W-1:0] e, input string tag);
        rst_a              = rst;
        bus_a.enable       = en;
        bus_a.phase_cnt_in = ph;
        bus_a.clear_err    = clr;
        @(posedge ioclk);
        exp_qa.push_back(e);
        tag_qa.push_back(tag);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic en, input logic [1:0] ph,
                          input logic clr, input logic [W-1:0] e, input string tag);
        rst_b              = rst;
        bus_b.enable       = en;
        bus_b.phase_cnt_in = ph;
        bus_b.clear_err    = clr;
        @(posedge ioclk);
        exp_qb.push_back(e);
        tag_qb.push_back(tag);
        #1;
    endtask

    // good sample while locked, R=4, load_phase=1
    task automatic locked_a(input logic [1:0] ph, input logic [7:0] ec);
        step_a(0, 1, ph, 0, pk(2, 1, 0, ph == 2'd1, ph == 2'd3, ec), "a_locked_run");
    endtask

    // good sample while locked, R=3, load_phase=1
    task automatic locked_b(input logic [1:0] ph, input logic [7:0] ec);
        step_b(0, 1, ph, 0, pk(2, 1, 0, ph == 2'd1, ph == 2'd2, ec), "b_locked_run");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; bus_a.enable = 1'b0; bus_a.phase_cnt_in = '0; bus_a.clear_err = 1'b0;
        rst_b = 1'b1; bus_b.enable = 1'b0; bus_b.phase_cnt_in = '0; bus_b.clear_err = 1'b0;
        bus_a.load_phase = 2'd1;
        bus_b.load_phase = 2'd1;

        // ---------------- instance A: R=4, LOCK=8, ERR=2 ----------------
        step_a(1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0), "a_reset");
        step_a(1, 1, 1, 0, pk(0, 0, 0, 0, 0, 0), "a_reset_over_enable");
        step_a(0, 1, 3, 0, pk(1, 0, 0, 0, 0, 0), "a_idle_to_acquire");
        step_a(0, 1, 0, 0, pk(1, 0, 0, 0, 0, 0), "a_reference");
        for (int i = 1; i <= 8; i++)
            step_a(0, 1, 2'(i % 4), 0,
                   (i == 8) ? pk(2, 1, 0, 0, 0, 0) : pk(1, 0, 0, 0, 0, 0), "a_acquire");
        for (int i = 1; i <= 8; i++) locked_a(2'(i % 4), 8'd0);

        // single glitch: 0,1,3,0 -- rx suppressed on the bad 3, lock held
        locked_a(2'd1, 8'd0);
        step_a(0, 1, 3, 0, pk(2, 1, 0, 0, 0, 1), "a_single_glitch");
        locked_a(2'd0, 8'd1);
        locked_a(2'd1, 8'd1);
        locked_a(2'd2, 8'd1);
        locked_a(2'd3, 8'd1);
        locked_a(2'd0, 8'd1);

        // double glitch: 1,3,1 -- second consecutive bad drops lock
        locked_a(2'd1, 8'd1);
        step_a(0, 1, 3, 0, pk(2, 1, 0, 0, 0, 2), "a_double_glitch_1");
        step_a(0, 1, 1, 0, pk(1, 0, 1, 0, 0, 3), "a_double_glitch_lost");
        for (int i = 0; i < 8; i++)
            step_a(0, 1, 2'((2 + i) % 4), 0,
                   (i == 7) ? pk(2, 1, 0, 0, 0, 3) : pk(1, 0, 0, 0, 0, 3), "a_relock");
        locked_a(2'd2, 8'd3);
        locked_a(2'd3, 8'd3);
        locked_a(2'd0, 8'd3);

        // enable drop while locked on a would-be tx sample
        step_a(0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3), "a_enable_drop");
        step_a(0, 0, 2, 0, pk(0, 0, 0, 0, 0, 3), "a_idle_hold");

        // acquire reset: 5 good, then 2 after 3, then 8 more good needed
        step_a(0, 1, 0, 0, pk(1, 0, 0, 0, 0, 3), "a_reenable");
        step_a(0, 1, 2, 0, pk(1, 0, 0, 0, 0, 3), "a_reference_2");
        for (int i = 1; i <= 5; i++)
            step_a(0, 1, 2'((2 + i) % 4), 0, pk(1, 0, 0, 0, 0, 3), "a_acq_good5");
        step_a(0, 1, 2, 0, pk(1, 0, 0, 0, 0, 3), "a_acq_bad");
        for (int i = 1; i <= 8; i++)
            step_a(0, 1, 2'((2 + i) % 4), 0,
                   (i == 8) ? pk(2, 1, 0, 0, 0, 3) : pk(1, 0, 0, 0, 0, 3), "a_acq_regain");
        locked_a(2'd3, 8'd3);
        locked_a(2'd0, 8'd3);

        // reset during ACQUIRE clears everything including err_cnt
        step_a(0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3), "a_enable_drop_2");
        step_a(0, 1, 0, 0, pk(1, 0, 0, 0, 0, 3), "a_reenable_2");
        step_a(0, 1, 0, 0, pk(1, 0, 0, 0, 0, 3), "a_reference_3");
        step_a(0, 1, 1, 0, pk(1, 0, 0, 0, 0, 3), "a_acq_pre_rst_1");
        step_a(0, 1, 2, 0, pk(1, 0, 0, 0, 0, 3), "a_acq_pre_rst_2");
        step_a(1, 1, 3, 0, pk(0, 0, 0, 0, 0, 0), "a_reset_in_acquire");
        step_a(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0), "a_after_reset");
        rst_a = 1'b1;

        // ---------------- instance B: R=3, LOCK=8, ERR=400 ----------------
        step_b(1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0), "b_reset");
        step_b(0, 1, 2, 0, pk(1, 0, 0, 0, 0, 0), "b_idle_to_acquire");
        step_b(0, 1, 0, 0, pk(1, 0, 0, 0, 0, 0), "b_reference");
        for (int i = 1; i <= 8; i++)
            step_b(0, 1, 2'(i % 3), 0,
                   (i == 8) ? pk(2, 1, 0, 0, 0, 0) : pk(1, 0, 0, 0, 0, 0), "b_acquire");

        // out-of-range value 3 is always bad, as is the sample after it
        step_b(0, 1, 3, 0, pk(2, 1, 0, 0, 0, 1), "b_out_of_range");
        step_b(0, 1, 2, 0, pk(2, 1, 0, 0, 0, 2), "b_after_out_of_range");
        locked_b(2'd0, 8'd2);
        locked_b(2'd1, 8'd2);
        locked_b(2'd2, 8'd2);

        // 300 consecutive bad samples: err_cnt saturates at 255, lock held
        for (int i = 1; i <= 300; i++)
            step_b(0, 1, 1, 0, pk(2, 1, 0, 0, 0, (2 + i > 255) ? 8'd255 : 8'(2 + i)), "b_saturate");
        step_b(0, 1, 1, 1, pk(2, 1, 0, 0, 0, 0), "b_clear_with_bad");
        step_b(0, 1, 1, 0, pk(2, 1, 0, 0, 0, 1), "b_bad_after_clear");
        locked_b(2'd2, 8'd1);
        locked_b(2'd0, 8'd1);

        // load_phase out of range never fires; load_phase=R-1 fires with rx
        bus_b.load_phase = 2'd3;
        step_b(0, 1, 1, 0, pk(2, 1, 0, 0, 0, 1), "b_load_phase_oor");
        bus_b.load_phase = 2'd2;
        step_b(0, 1, 2, 0, pk(2, 1, 0, 1, 1, 1), "b_tx_rx_together");
        step_b(0, 1, 0, 0, pk(2, 1, 0, 0, 0, 1), "b_tail");
        rst_b = 1'b1;

        @(negedge ioclk);
        #1;
        n_checks++;
        if (exp_qa.size() == 0 && exp_qb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain: got %0d/%0d entries left, want 0/0", exp_qa.size(), exp_qb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
